// File: rtl/lbist_session_ctrl.sv
// Logic-BIST session sequencer for riscv_core_bist: reset, pattern run, settle,
// result check, then release the core to functional mode or park it in reset.
//
// state    | meaning
// IDLE     | no session since reset; core held in reset
// PRE_RST  | core reset asserted with test_mode high before patterns
// RUN      | core out of reset, test_mode patterns applied
// SETTLE   | MISR/compare flush before go_nogo is trusted
// CHECK    | single cycle; go_nogo sampled into pass/fail
// POST_RST | core reset asserted with test_mode low after the session
// FUNC     | passed; core released with fetch enabled
// HALT     | failed or aborted; core parked in reset
module lbist_session_ctrl #(
  parameter int PATTERN_CYCLES = 1024,
  parameter int RST_CYCLES     = 4,
  parameter int SETTLE_CYCLES  = 2,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic                 go_nogo_i,
  output logic                 core_rst_o,
  output logic                 test_mode_o,
  output logic                 fetch_enable_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic                 fail_o,
  output logic [CNT_WIDTH-1:0] pat_cnt_o
);

  typedef enum logic [2:0] {
    IDLE, PRE_RST, RUN, SETTLE, CHECK, POST_RST, FUNC, HALT
  } state_t;

  localparam logic [CNT_WIDTH-1:0] RST_LOAD    = CNT_WIDTH'(RST_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] PAT_LOAD    = CNT_WIDTH'(PATTERN_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] SETTLE_LOAD = CNT_WIDTH'(SETTLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] ONE         = CNT_WIDTH'(1);

  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;

  // Output pattern {core_rst, test_mode, busy, fetch_enable} of the state being entered.
  function automatic logic [3:0] state_outs(input state_t s);
    case (s)
      IDLE:                state_outs = 4'b1000;
      PRE_RST:             state_outs = 4'b1110;
      RUN, SETTLE, CHECK:  state_outs = 4'b0110;
      POST_RST:            state_outs = 4'b1010;
      FUNC:                state_outs = 4'b0001;
      default:             state_outs = 4'b1000;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      {core_rst_o, test_mode_o, busy_o, fetch_enable_o} <= state_outs(IDLE);
      done_o    <= 1'b0;
      pass_o    <= 1'b0;
      fail_o    <= 1'b0;
      pat_cnt_o <= '0;
    end else begin
      case (state)
        IDLE, FUNC, HALT: begin
          if (start_i) begin
            state     <= PRE_RST;
            cnt       <= RST_LOAD;
            {core_rst_o, test_mode_o, busy_o, fetch_enable_o} <= state_outs(PRE_RST);
            done_o    <= 1'b0;
            pass_o    <= 1'b0;
            fail_o    <= 1'b0;
            pat_cnt_o <= '0;
          end
        end
        PRE_RST, RUN, SETTLE, CHECK: begin
          // Abort takes priority over every in-session transition, including CHECK.
          if (abort_i) begin
            state  <= POST_RST;
            cnt    <= RST_LOAD;
            {core_rst_o, test_mode_o, busy_o, fetch_enable_o} <= state_outs(POST_RST);
            pass_o <= 1'b0;
            fail_o <= 1'b1;
          end else begin
            case (state)
              PRE_RST: begin
                if (cnt == '0) begin
                  state <= RUN;
                  cnt   <= PAT_LOAD;
                  {core_rst_o, test_mode_o, busy_o, fetch_enable_o} <= state_outs(RUN);
                end else begin
                  cnt <= cnt - ONE;
                end
              end
              RUN: begin
                pat_cnt_o <= pat_cnt_o + ONE;
                if (cnt == '0) begin
                  state <= SETTLE;
                  cnt   <= SETTLE_LOAD;
                  {core_rst_o, test_mode_o, busy_o, fetch_enable_o} <= state_outs(SETTLE);
                end else begin
                  cnt <= cnt - ONE;
                end
              end
              SETTLE: begin
                if (cnt == '0) begin
                  state <= CHECK;
                  {core_rst_o, test_mode_o, busy_o, fetch_enable_o} <= state_outs(CHECK);
                end else begin
                  cnt <= cnt - ONE;
                end
              end
              default: begin
                state  <= POST_RST;
                cnt    <= RST_LOAD;
                {core_rst_o, test_mode_o, busy_o, fetch_enable_o} <= state_outs(POST_RST);
                pass_o <= go_nogo_i;
                fail_o <= ~go_nogo_i;
              end
            endcase
          end
        end
        POST_RST: begin
          if (cnt == '0) begin
            done_o <= 1'b1;
            if (pass_o) begin
              state <= FUNC;
              {core_rst_o, test_mode_o, busy_o, fetch_enable_o} <= state_outs(FUNC);
            end else begin
              state <= HALT;
              {core_rst_o, test_mode_o, busy_o, fetch_enable_o} <= state_outs(HALT);
            end
          end else begin
            cnt <= cnt - ONE;
          end
        end
        default: begin
          state <= IDLE;
          {core_rst_o, test_mode_o, busy_o, fetch_enable_o} <= state_outs(IDLE);
        end
      endcase
    end
  end

endmodule
